inv_tree_stim_ctrl: RTL and testbench

Clocked stimulus sequencer and checker for the four-output inverter tree under delay characterisation. Drives the tree input with a programmable pulse train of high/low lengths and pulse count. Samples all four tree outputs at the end of every phase and counts polarity mismatches. Sits between the test harness (start/config/status) and the combinational tree (din/dout).

---
 rtl/inv_tree_ctrl_pkg.sv | 29 ++
 rtl/inv_tree_phase_timer.sv | 37 +++
 rtl/inv_tree_stim_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_inv_tree_stim_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_tree_ctrl_pkg.sv
// Shared constants, state encoding and the polarity helper for the
// inverter-tree stimulus controller.
package inv_tree_ctrl_pkg;

  localparam int PW_W_DEF     = 8;
  localparam int CNT_W_DEF    = 16;
  localparam int NOUT_DEF     = 4;
  localparam int DRAIN_CYCLES = 4;

  // Odd tree depth: every output is the complement of the drive.
  localparam bit EXPECT_INVERTED = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_HIGH  = 3'd1;
  localparam state_t ST_LOW   = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  function automatic logic expected_dout(input logic din);
    if (EXPECT_INVERTED) begin
      return ~din;
    end else begin
      return din;
    end
  endfunction

endpackage

// File: rtl/inv_tree_phase_timer.sv
// Loadable down-counter shared by the HIGH, LOW and DRAIN phases; zero marks
// the last cycle of the current phase.
module inv_tree_phase_timer #(
  parameter int PW_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PW_W-1:0] load_val,
  output logic            zero
);

  logic [PW_W-1:0] cnt_q;
  logic [PW_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {PW_W{1'b0}}) begin
      cnt_d = cnt_q - {{(PW_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {PW_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {PW_W{1'b0}});

endmodule

// File: rtl/inv_tree_stim_ctrl.sv
// Pulse-train sequencer and polarity checker for the inverter tree.
// Optional glitch counting is enabled by defining INV_TREE_GLITCH_CHECK_EN.
module inv_tree_stim_ctrl
  import inv_tree_ctrl_pkg::*;
#(
  parameter int PW_W  = PW_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int NOUT  = NOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PW_W-1:0]  cfg_high_len,
  input  logic [PW_W-1:0]  cfg_low_len,
  input  logic [CNT_W-1:0] cfg_num_pulses,
  input  logic [NOUT-1:0]  dout_i,
  output logic             din_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam int               PC_W       = $clog2(NOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [PW_W-1:0]  DRAIN_LOAD = PW_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE_PULSE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             din_q, din_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             flag_q, flag_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [PW_W-1:0]  hl_m1_q, hl_m1_d;
  logic [PW_W-1:0]  ll_m1_q, ll_m1_d;

  logic             tmr_load_s;
  logic [PW_W-1:0]  tmr_val_s;
  logic             tmr_zero_s;
  logic             clr_s;
  logic             in_phase_s;
  logic             sample_s;
  logic [NOUT-1:0]  miss_s;
  logic [CNT_W:0]   err_sum_s;

  // A zero length still holds the level for one cycle.
  function automatic logic [PW_W-1:0] len_m1(input logic [PW_W-1:0] len);
    if (len == {PW_W{1'b0}}) begin
      return {PW_W{1'b0}};
    end else begin
      return len - {{(PW_W-1){1'b0}}, 1'b1};
    end
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [NOUT-1:0] v);
    logic [PC_W-1:0] c;
    c = {PC_W{1'b0}};
    for (int i = 0; i < NOUT; i++) begin
      c = c + {{(PC_W-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  inv_tree_phase_timer #(.PW_W(PW_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rem_d      = rem_q;
    hl_m1_d    = hl_m1_q;
    ll_m1_d    = ll_m1_q;
    tmr_load_s = 1'b0;
    tmr_val_s  = {PW_W{1'b0}};
    clr_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr_s   = 1'b1;
          busy_d  = 1'b1;
          hl_m1_d = len_m1(cfg_high_len);
          ll_m1_d = len_m1(cfg_low_len);
          rem_d   = cfg_num_pulses;
          if (cfg_num_pulses == {CNT_W{1'b0}}) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_HIGH;
            din_d      = 1'b1;
            tmr_load_s = 1'b1;
            tmr_val_s  = len_m1(cfg_high_len);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (tmr_zero_s) begin
          state_d    = ST_LOW;
          din_d      = 1'b0;
          tmr_load_s = 1'b1;
          tmr_val_s  = ll_m1_q;
        end else begin
          state_d = ST_HIGH;
        end
      end
      ST_LOW: begin
        if (tmr_zero_s) begin
          rem_d      = rem_q - ONE_PULSE;
          tmr_load_s = 1'b1;
          if (rem_q == ONE_PULSE) begin
            state_d   = ST_DRAIN;
            tmr_val_s = DRAIN_LOAD;
          end else begin
            state_d   = ST_HIGH;
            din_d     = 1'b1;
            tmr_val_s = hl_m1_q;
          end
        end else begin
          state_d = ST_LOW;
        end
      end
      ST_DRAIN: begin
        if (tmr_zero_s) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        din_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Mismatches are sampled on the final cycle of every HIGH/LOW phase.
  always_comb begin
    in_phase_s = (state_q == ST_HIGH) || (state_q == ST_LOW);
    sample_s   = in_phase_s && tmr_zero_s;
    miss_s     = dout_i ^ {NOUT{expected_dout(din_q)}};
    err_sum_s  = {1'b0, err_q} + {{(CNT_W+1-PC_W){1'b0}}, popcount(miss_s)};
    if (clr_s) begin
      err_d = {CNT_W{1'b0}};
    end else if (sample_s) begin
      err_d = err_sum_s[CNT_W] ? CNT_MAX : err_sum_s[CNT_W-1:0];
    end else begin
      err_d = err_q;
    end
    flag_d = (err_d != {CNT_W{1'b0}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= {CNT_W{1'b0}};
      flag_q  <= 1'b0;
      rem_q   <= {CNT_W{1'b0}};
      hl_m1_q <= {PW_W{1'b0}};
      ll_m1_q <= {PW_W{1'b0}};
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      flag_q  <= flag_d;
      rem_q   <= rem_d;
      hl_m1_q <= hl_m1_d;
      ll_m1_q <= ll_m1_d;
    end
  end

  assign din_o    = din_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_cnt  = err_q;
  assign err_flag = flag_q;

`ifdef INV_TREE_GLITCH_CHECK_EN
  logic [NOUT-1:0]   prev_q;
  logic [2*NOUT-1:0] ecnt_q, ecnt_d;
  logic [CNT_W-1:0]  glitch_q, glitch_d;
  logic [NOUT-1:0]   edge_s;
  logic [NOUT-1:0]   hit_s;
  logic [CNT_W:0]    glitch_sum_s;

  // Per-bit edge counts saturate at 2; the second edge in a phase is the glitch.
  always_comb begin
    edge_s = dout_i ^ prev_q;
    ecnt_d = ecnt_q;
    hit_s  = {NOUT{1'b0}};
    for (int i = 0; i < NOUT; i++) begin
      hit_s[i] = in_phase_s & edge_s[i] & (ecnt_q[2*i +: 2] == 2'd1);
      if (tmr_load_s) begin
        ecnt_d[2*i +: 2] = 2'd0;
      end else if (in_phase_s && edge_s[i] && (ecnt_q[2*i +: 2] != 2'd2)) begin
        ecnt_d[2*i +: 2] = ecnt_q[2*i +: 2] + 2'd1;
      end else begin
        ecnt_d[2*i +: 2] = ecnt_q[2*i +: 2];
      end
    end
    glitch_sum_s = {1'b0, glitch_q} + {{(CNT_W+1-PC_W){1'b0}}, popcount(hit_s)};
    if (clr_s) begin
      glitch_d = {CNT_W{1'b0}};
    end else if (hit_s != {NOUT{1'b0}}) begin
      glitch_d = glitch_sum_s[CNT_W] ? CNT_MAX : glitch_sum_s[CNT_W-1:0];
    end else begin
      glitch_d = glitch_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q   <= {NOUT{1'b0}};
      ecnt_q   <= {(2*NOUT){1'b0}};
      glitch_q <= {CNT_W{1'b0}};
    end else begin
      prev_q   <= dout_i;
      ecnt_q   <= ecnt_d;
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_inv_tree_stim_ctrl.sv
// Scoreboard bench for inv_tree_stim_ctrl: expected per-cycle {din_o,busy,done}
// and end-of-run error counts are queued at launch and popped as the DUT runs.
module tb_inv_tree_stim_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  hl, ll;
  logic [15:0] np;
  logic [3:0]  dout;
  logic        din, busy, done, err_flag;
  logic [15:0] err_cnt, glitch_cnt;
  logic [3:0]  force_mask, force_val, glitch_mask;

  logic        s_start;
  logic [7:0]  s_hl, s_ll;
  logic [3:0]  s_np;
  logic [3:0]  s_dout;
  logic        s_din, s_busy, s_done, s_flag;
  logic [3:0]  s_err, s_glitch;

  int          n_checks;
  int          n_fail;
  logic [2:0]  exp_q[$];
  logic [15:0] err_exp_q[$];

  // Model of an odd-depth tree, with stuck-at and glitch injection.
  assign dout   = (({4{~din}} & ~force_mask) | (force_val & force_mask)) ^ glitch_mask;
  // Saturation instance sees a non-inverting tree: every bit is wrong.
  assign s_dout = {4{s_din}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inv_tree_stim_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_high_len(hl), .cfg_low_len(ll),
    .cfg_num_pulses(np), .dout_i(dout), .din_o(din), .busy(busy), .done(done),
    .err_cnt(err_cnt), .err_flag(err_flag), .glitch_cnt(glitch_cnt)
  );

  inv_tree_stim_ctrl #(.PW_W(8), .CNT_W(4), .NOUT(4)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .cfg_high_len(s_hl), .cfg_low_len(s_ll),
    .cfg_num_pulses(s_np), .dout_i(s_dout), .din_o(s_din), .busy(s_busy), .done(s_done),
    .err_cnt(s_err), .err_flag(s_flag), .glitch_cnt(s_glitch)
  );

  task automatic build_expect(input int h, input int l, input int p,
                              input int nh, input int nl, input int maxv);
    int hh;
    int lw;
    int errs;
    hh = (h == 0) ? 1 : h;
    lw = (l == 0) ? 1 : l;
    for (int k = 0; k < p; k++) begin
      for (int i = 0; i < hh; i++) exp_q.push_back(3'b110);
      for (int i = 0; i < lw; i++) exp_q.push_back(3'b010);
    end
    if (p > 0) begin
      for (int i = 0; i < 4; i++) exp_q.push_back(3'b010);
    end
    exp_q.push_back(3'b011);
    exp_q.push_back(3'b000);
    errs = p * (nh + nl);
    if (errs > maxv) errs = maxv;
    err_exp_q.push_back(16'(errs));
  endtask

  // Config is scrambled right after acceptance to prove it was shadowed.
  task automatic launch(input logic [7:0] h, input logic [7:0] l, input logic [15:0] p);
    @(negedge clk);
    hl = h; ll = l; np = p; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; hl = 8'd77; ll = 8'd99; np = 16'd5;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({din, busy, done, err_flag} !== 4'b0000 || err_cnt !== 16'd0 || glitch_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values: got din/busy/done/flag=%b err=%0d glitch=%0d, want 0000/0/0",
               {din, busy, done, err_flag}, err_cnt, glitch_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({din, busy, done, s_din, s_busy, s_done} !== 6'b000000 || s_err !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got %b err=%0d, want 000000 err=0",
               {din, busy, done, s_din, s_busy, s_done}, s_err);
    end
  endtask

  task automatic test_pulse_train();
    int         h_t[4] = '{3, 3, 0, 5};
    int         l_t[4] = '{2, 2, 0, 5};
    int         p_t[4] = '{2, 2, 1, 0};
    logic [3:0] fm_t[4] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000};
    logic [2:0] e;
    logic [15:0] ee;
    int         cyc;
    for (int t = 0; t < 4; t++) begin
      force_mask = fm_t[t];
      force_val  = 4'b0000;
      build_expect(h_t[t], l_t[t], p_t[t], $countones(fm_t[t] & force_val),
                   $countones(fm_t[t] & ~force_val), 65535);
      launch(8'(h_t[t]), 8'(l_t[t]), 16'(p_t[t]));
      cyc = 0;
      while (exp_q.size() > 0) begin
        @(negedge clk);
        cyc++;
        e = exp_q.pop_front();
        n_checks++;
        if ({din, busy, done} !== e) begin
          n_fail++;
          $display("FAIL train%0d_wave cycle %0d: got din/busy/done=%b want %b",
                   t, cyc, {din, busy, done}, e);
        end
      end
      ee = err_exp_q.pop_front();
      n_checks++;
      if (err_cnt !== ee || err_flag !== (ee != 16'd0) || glitch_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL train%0d_errors: got err=%0d flag=%b glitch=%0d want err=%0d flag=%b glitch=0",
                 t, err_cnt, err_flag, glitch_cnt, ee, (ee != 16'd0));
      end
    end
    force_mask = 4'b0000;
  endtask

  task automatic test_saturation_ignore();
    logic [2:0]  e;
    logic [15:0] ee;
    int          k;
    build_expect(1, 1, 3, 4, 4, 15);
    @(negedge clk);
    s_hl = 8'd1; s_ll = 8'd1; s_np = 4'd3; s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      n_checks++;
      if ({s_din, s_busy, s_done} !== e) begin
        n_fail++;
        $display("FAIL sat_wave cycle %0d: got din/busy/done=%b want %b",
                 k, {s_din, s_busy, s_done}, e);
      end
      // Starts mid-run and during DONE must be ignored.
      s_start = (k == 3) || e[0];
      if (k == 3) begin
        s_hl = 8'd9; s_np = 4'd9;
      end
    end
    s_start = 1'b0;
    ee = err_exp_q.pop_front();
    n_checks++;
    if (s_err !== ee[3:0] || s_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_errors: got err=%0d flag=%b want err=%0d flag=1", s_err, s_flag, ee);
    end
  endtask

  task automatic test_glitch();
    logic [2:0]  e;
    logic [15:0] ee;
    logic [15:0] g_exp;
    int          k;
`ifdef INV_TREE_GLITCH_CHECK_EN
    g_exp = 16'd1;
`else
    g_exp = 16'd0;
`endif
    build_expect(5, 2, 1, 0, 0, 65535);
    launch(8'd5, 8'd2, 16'd1);
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      k++;
      e = exp_q.pop_front();
      n_checks++;
      if ({din, busy, done} !== e) begin
        n_fail++;
        $display("FAIL glitch_wave cycle %0d: got %b want %b", k, {din, busy, done}, e);
      end
      if (k == 2) glitch_mask = 4'b0001;
      if (k == 3) glitch_mask = 4'b0000;
    end
    ee = err_exp_q.pop_front();
    n_checks++;
    if (glitch_cnt !== g_exp || err_cnt !== ee) begin
      n_fail++;
      $display("FAIL glitch_count: got glitch=%0d err=%0d want glitch=%0d err=%0d",
               glitch_cnt, err_cnt, g_exp, ee);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    force_mask = 4'b1111;
    force_val  = 4'b1111;
    launch(8'd1, 8'd5, 16'd3);
    @(negedge clk);
    n_checks++;
    if (din !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_high: got din=%b busy=%b want 1 1", din, busy);
    end
    @(negedge clk);
    n_checks++;
    if (err_cnt !== 16'd4 || err_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_errs: got err=%0d flag=%b want 4 1", err_cnt, err_flag);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({din, busy, done, err_flag} !== 4'b0000 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got din/busy/done/flag=%b err=%0d want 0000 0",
               {din, busy, done, err_flag}, err_cnt);
    end
    force_mask = 4'b0000;
    force_val  = 4'b0000;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy || din) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midrun_no_done: got %0d active cycles after reset want 0", seen);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; hl = 8'd0; ll = 8'd0; np = 16'd0;
    force_mask = 4'b0000; force_val = 4'b0000; glitch_mask = 4'b0000;
    s_start = 1'b0; s_hl = 8'd0; s_ll = 8'd0; s_np = 4'd0;
    test_reset();
    test_pulse_train();
    test_saturation_ignore();
    test_glitch();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
